// File: rtl/addr_to_cart_pkg.sv
// addr_to_cart_pkg: screen geometry defaults and elaboration-time helpers shared
// by the linear-address to (x, y) converter.
package addr_to_cart_pkg;

  localparam int unsigned H_RES         = 640;
  localparam int unsigned V_RES         = 480;
  localparam int unsigned SCREEN_PIXELS = H_RES * V_RES;
  localparam int unsigned ADDR_W        = 19;
  localparam int unsigned COORD_W       = 10;

  // Number of trailing zero bits; the power-of-two part of a divisor is peeled off as a shift.
  function automatic int unsigned trailingZeros(input int unsigned v);
    int unsigned n;
    n = 0;
    if (v == 0) return 0;
    while (((v >> n) & 32'd1) == 32'd0) n++;
    return n;
  endfunction

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int unsigned bitsFor(input int unsigned maxVal);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((maxVal >> w) != 0)) w++;
    return w;
  endfunction

endpackage

// File: rtl/addr_divmod_const.sv
// addr_divmod_const: combinational quotient/remainder by a constant divisor.
// The quotient comes from a reciprocal multiply; the remainder is recovered by subtracting
// quotient * divisor from the dividend.
module addr_divmod_const
  import addr_to_cart_pkg::*;
#(
  parameter int unsigned DIVISOR = 5,
  parameter int unsigned IN_W    = 12,
  parameter int unsigned REM_W   = bitsFor(DIVISOR - 1)
) (
  input  logic [IN_W-1:0]  dividend,
  output logic [IN_W-1:0]  quot,
  output logic [REM_W-1:0] rem
);

  // With Shift = IN_W + ceil-ish log2(DIVISOR) and Mult = ceil(2^Shift / DIVISOR), the
  // reciprocal error stays below 1/DIVISOR for every IN_W-bit dividend, so the estimate is exact.
  localparam int unsigned DivBits = bitsFor(DIVISOR);
  localparam int unsigned Shift   = IN_W + DivBits;
  localparam int unsigned MultW   = Shift + 1;
  localparam int unsigned ProdW   = IN_W + MultW;
  localparam longint unsigned MultVal =
      ((64'd1 << Shift) + 64'(DIVISOR) - 64'd1) / 64'(DIVISOR);
  localparam logic [MultW-1:0] Mult = MultW'(MultVal);

  logic [ProdW-1:0] prod;
  logic [IN_W-1:0]  quotTimesDiv;

  // Reciprocal multiply for the quotient, then subtract back for the remainder.
  always_comb begin
    prod         = ProdW'(dividend) * ProdW'(Mult);
    quot         = IN_W'(prod >> Shift);
    quotTimesDiv = quot * IN_W'(DIVISOR);
    rem          = REM_W'(dividend - quotTimesDiv);
  end

endmodule

// File: rtl/addr_to_cart.sv
// addr_to_cart: converts a row-major linear pixel address into (x, y) plus an on-screen flag.
// H_RES is split into 2^k * odd; the low k address bits pass straight into x and only the
// coarse address (addr >> k) goes through the constant divider.
// Build option: define ADDR_TO_CART_PIPE_EN for a two-stage pipeline (latency 2);
// otherwise the conversion is one combinational step into the output register (latency 1).
module addr_to_cart #(
  parameter int unsigned H_RES   = addr_to_cart_pkg::H_RES,
  parameter int unsigned V_RES   = addr_to_cart_pkg::V_RES,
  parameter int unsigned ADDR_W  = addr_to_cart_pkg::ADDR_W,
  parameter int unsigned COORD_W = addr_to_cart_pkg::COORD_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  addr,
  output logic               out_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               in_screen
);
  import addr_to_cart_pkg::*;

  localparam int unsigned LowBits = trailingZeros(H_RES);
  localparam int unsigned OddDiv  = H_RES >> LowBits;
  localparam int unsigned CoarseW = ADDR_W - LowBits;
  localparam int unsigned RemW    = bitsFor(OddDiv - 1);
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'((64'd1 << LowBits) - 64'd1);

  logic [CoarseW-1:0] coarse;
  logic [CoarseW-1:0] quot;
  logic [RemW-1:0]    rem;

  assign coarse = CoarseW'(addr >> LowBits);

  addr_divmod_const #(
    .DIVISOR (OddDiv),
    .IN_W    (CoarseW),
    .REM_W   (RemW)
  ) u_divmod (
    .dividend (coarse),
    .quot     (quot),
    .rem      (rem)
  );

  // Operands feeding the final assembly stage.
  logic               asmValid;
  logic [CoarseW-1:0] asmQuot;
  logic [RemW-1:0]    asmRem;
  logic [ADDR_W-1:0]  asmLow;

`ifdef ADDR_TO_CART_PIPE_EN
  logic               s1Valid;
  logic [CoarseW-1:0] s1Quot;
  logic [RemW-1:0]    s1Rem;
  logic [ADDR_W-1:0]  s1Low;

  // Stage 1 valid bit; cleared by reset so in-flight addresses are dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) s1Valid <= 1'b0;
    else         s1Valid <= in_valid;
  end

  // Stage 1 data: coarse quotient, remainder and pass-through low bits, loaded only on valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Quot <= '0;
      s1Rem  <= '0;
      s1Low  <= '0;
    end else if (in_valid) begin
      s1Quot <= quot;
      s1Rem  <= rem;
      s1Low  <= addr & LowMask;
    end
  end

  assign asmValid = s1Valid;
  assign asmQuot  = s1Quot;
  assign asmRem   = s1Rem;
  assign asmLow   = s1Low;
`else
  assign asmValid = in_valid;
  assign asmQuot  = quot;
  assign asmRem   = rem;
  assign asmLow   = addr & LowMask;
`endif

  logic [COORD_W-1:0] xNext;
  logic [COORD_W-1:0] yNext;
  logic               inScreenNext;

  // Final assembly: x rejoins remainder and low bits; addr < H_RES*V_RES iff row < V_RES.
  always_comb begin
    xNext        = COORD_W'((ADDR_W'(asmRem) << LowBits) | asmLow);
    yNext        = COORD_W'(asmQuot);
    inScreenNext = 32'(asmQuot) < V_RES;
  end

  // Output valid bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) out_valid <= 1'b0;
    else         out_valid <= asmValid;
  end

  // Output data registers hold the last valid result between valid cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x         <= '0;
      y         <= '0;
      in_screen <= 1'b0;
    end else if (asmValid) begin
      x         <= xNext;
      y         <= yNext;
      in_screen <= inScreenNext;
    end
  end

endmodule

// File: tb/tb_addr_to_cart.sv
// tb_addr_to_cart: directed and streaming stimulus for addr_to_cart. A queue model built from
// plain mod/div arithmetic predicts each output cycle; literal vectors pin the expected values.
// Latency follows the ADDR_TO_CART_PIPE_EN build option.
module tb_addr_to_cart;

  localparam int unsigned HRes = 640;
  localparam int unsigned VRes = 480;
  localparam int unsigned MaxAddr = 524287;
`ifdef ADDR_TO_CART_PIPE_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic [18:0] addr = '0;
  logic        out_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        in_screen;

  int passCnt = 0;
  int totalCnt = 0;
  longint cyc = 0;

  typedef struct {
    longint      due;
    int unsigned a;
  } pend_t;
  pend_t pend[$];

  int unsigned holdX = 0;
  int unsigned holdY = 0;
  int unsigned holdS = 0;
  int unsigned expV;
  int unsigned curA;

  addr_to_cart dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .addr      (addr),
    .out_valid (out_valid),
    .x         (x),
    .y         (y),
    .in_screen (in_screen)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Record accepted addresses with the cycle their result is due.
  always @(posedge clock) begin
    if (resetn && in_valid) pend.push_back('{due: cyc + Lat, a: int'(addr)});
    cyc <= cyc + 1;
  end

  always @(negedge resetn) pend.delete();

  // Per-cycle comparison against the arithmetic model.
  always @(negedge clock) begin
    if (!resetn) begin
      holdX = 0;
      holdY = 0;
      holdS = 0;
      chk("reset out_valid", out_valid, 0);
      chk("reset x", x, 0);
      chk("reset y", y, 0);
      chk("reset in_screen", in_screen, 0);
    end else begin
      expV = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        expV  = 1;
        curA  = pend[0].a;
        void'(pend.pop_front());
        holdX = curA % HRes;
        holdY = curA / HRes;
        holdS = (curA < HRes * VRes) ? 1 : 0;
      end
      chk("out_valid", out_valid, expV);
      chk("x", x, holdX);
      chk("y", y, holdY);
      chk("in_screen", in_screen, holdS);
    end
  end

  task automatic drive(input bit v, input int unsigned a);
    @(negedge clock);
    #1;
    in_valid = v;
    addr     = 19'(a);
  endtask

  task automatic lit(input int unsigned a, input int unsigned ex, input int unsigned ey,
                     input int unsigned es);
    drive(1'b1, a);
    repeat (Lat + 1) drive(1'b0, 0);
    chk($sformatf("lit x @%0d", a), x, ex);
    chk($sformatf("lit y @%0d", a), y, ey);
    chk($sformatf("lit in_screen @%0d", a), in_screen, es);
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish, got cycle %0d, expected < 300000", cyc);
    $fatal(1);
  end

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1 resetn = 1'b1;

    // Literal vectors.
    lit(0, 0, 0, 1);
    lit(1, 1, 0, 1);
    lit(1279, 639, 1, 1);
    lit(307199, 639, 479, 1);
    lit(307200, 0, 480, 0);
    lit(524287, 127, 819, 0);

    // Row boundary back-to-back.
    drive(1'b1, 639);
    drive(1'b1, 640);
    repeat (Lat - 1) drive(1'b0, 0);
    chk("b2b first x", x, 639);
    chk("b2b first y", y, 0);
    drive(1'b0, 0);
    chk("b2b second x", x, 0);
    chk("b2b second y", y, 1);

    // Contiguous sweep over the first 64 rows.
    for (int a = 0; a < 40960; a++) drive(1'b1, a);
    // Strided sweep across the whole address space.
    for (int a = 0; a <= int'(MaxAddr); a += 97) drive(1'b1, a);
    // Top of the address space.
    for (int a = int'(MaxAddr) - 2047; a <= int'(MaxAddr); a++) drive(1'b1, a);

    // Random gaps with a mid-stream reset pulse.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset x", x, 0);
        chk("async reset y", y, 0);
        chk("async reset in_screen", in_screen, 0);
        repeat (3) drive(1'b1, $urandom_range(0, MaxAddr));
        @(negedge clock);
        #1;
        resetn   = 1'b1;
        in_valid = 1'b1;
        addr     = 19'($urandom_range(0, MaxAddr));
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, MaxAddr));
      end
    end

    repeat (Lat + 2) drive(1'b0, 0);
    chk("pending drained", pend.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
